// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and port ids.
// Optional feature macro used by this block: DMEM_ARB_RR_EN (round-robin tie breaking).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two memory requesters.
// DMEM_ARB_RR_EN: ties alternate using last_grant; otherwise port 0 always wins ties.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef DMEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic any_req,
  output logic win
);

  always_comb begin
    any_req = req0 | req1;
`ifdef DMEM_ARB_RR_EN
    if (req0 && req1) begin
      win = ~last_grant;
    end else if (req1) begin
      win = PORT_DBG;
    end else begin
      win = PORT_CPU;
    end
`else
    win = (req1 && !req0) ? PORT_DBG : PORT_CPU;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer (IDLE -> ACCESS -> RESP) for a single-cycle data memory.
// DMEM_ARB_RR_EN selects round-robin tie breaking; default build uses fixed priority to port 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy,
  output logic          grant_id
);

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e          state;
  logic            acc_we;
  logic            any_req;
  logic            win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wd;
  logic            sel_in_range;
  logic            acc_in_range;
  logic [DW-1:0]   cap_data;
`ifdef DMEM_ARB_RR_EN
  logic            last_grant;
`endif

  dmem_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
`ifdef DMEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .any_req    (any_req),
    .win        (win)
  );

  always_comb begin
    sel_we   = we0;
    sel_addr = addr0;
    sel_wd   = wdata0;
    if (win == PORT_DBG) begin
      sel_we   = we1;
      sel_addr = addr1;
      sel_wd   = wdata1;
    end
  end

  assign sel_in_range = ({1'b0, sel_addr} < DEPTH_W);
  assign acc_in_range = ({1'b0, mem_a} < DEPTH_W);
  // Writes and out-of-range accesses return zero rather than whatever mem_rd shows.
  assign cap_data     = (acc_we || !acc_in_range) ? '0 : mem_rd;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      acc_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      mem_we     <= 1'b0;
      grant_id   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state    <= ST_ACCESS;
            grant_id <= win;
            mem_a    <= sel_addr;
            mem_wd   <= sel_wd;
            acc_we   <= sel_we;
            mem_we   <= sel_we & sel_in_range;
`ifdef DMEM_ARB_RR_EN
            last_grant <= win;
`endif
          end
        end
        ST_ACCESS: begin
          if (grant_id == PORT_DBG) begin
            ack1   <= 1'b1;
            err1   <= ~acc_in_range;
            rdata1 <= cap_data;
          end else begin
            ack0   <= 1'b1;
            err0   <= ~acc_in_range;
            rdata0 <= cap_data;
          end
          mem_we <= 1'b0;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, corner-case sequences and a randomized
// phase against a slot-level model. Tie-order expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          d_req [2];
  logic          d_we  [2];
  logic [AW-1:0] d_addr[2];
  logic [DW-1:0] d_wd  [2];

  logic          ack0, ack1, err0, err1, mem_we, busy, grant_id;
  logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;

  // Memory owned by the bench: combinational read, posedge write, low 8 address bits index it.
  logic [DW-1:0] mem [256];
  assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:0]] : '0;
  always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

  dmem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(d_req[0]), .req1(d_req[1]), .we0(d_we[0]), .we1(d_we[1]),
    .addr0(d_addr[0]), .addr1(d_addr[1]), .wdata0(d_wd[0]), .wdata1(d_wd[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd), .busy(busy), .grant_id(grant_id)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state
  logic [DW-1:0] model_mem [256];
  bit            known     [256];
  logic [DW-1:0] hold_rd   [2];
  bit            m_last;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic clear_drive();
    for (int p = 0; p < 2; p++) begin
      d_req[p] = 1'b0; d_we[p] = 1'b0; d_addr[p] = '0; d_wd[p] = '0;
    end
  endtask

  task automatic do_reset();
    clear_drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_rd[0] = '0;
    hold_rd[1] = '0;
    m_last = 1'b1;
  endtask

  function automatic logic ack_of(input bit p);
    return p ? ack1 : ack0;
  endfunction

  // Single transaction on an idle arbiter; caller is just after a negedge.
  task automatic run_one(input vec_t v, input string tag);
    int  ack_at = 0;
    int  we_cnt = 0;
    int  other  = 0;
    bit  in_rng = (v.addr < 32'd256);
    d_req[v.port] = 1'b1; d_we[v.port] = v.we; d_addr[v.port] = v.addr; d_wd[v.port] = v.wdata;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_mem_a"}, mem_a, v.addr);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_grant"}, grant_id, v.port);
        if (v.we) check({tag, "_mem_wd"}, mem_wd, v.wdata);
      end
      if (mem_we) we_cnt++;
      if (ack_of(!v.port)) other++;
      if (ack_of(v.port) && ack_at == 0) begin
        ack_at = c;
        check({tag, "_rdata"}, v.port ? rdata1 : rdata0, v.exp_rd);
        check({tag, "_err"}, v.port ? err1 : err0, v.exp_err);
        d_req[v.port] = 1'b0;
        if (v.we && in_rng) begin
          model_mem[v.addr[7:0]] = v.wdata;
          known[v.addr[7:0]] = 1'b1;
        end
        hold_rd[v.port] = v.exp_rd;
      end
    end
    check({tag, "_ack_cycle"}, ack_at, 2);
    check({tag, "_we_cycles"}, we_cnt, (v.we && in_rng) ? 1 : 0);
    check({tag, "_other_ack"}, other, 0);
  endtask

  task automatic tie_test();
    bit order[$];
    bit exp_ord[4];
`ifdef DMEM_ARB_RR_EN
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'd1;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'd2;
    for (int c = 0; c < 20 && order.size() < 4; c++) begin
      @(negedge clk);
      if (ack0) begin
        order.push_back(1'b0);
        check("tie_rdata0", rdata0, model_mem[1]);
      end
      if (ack1) begin
        order.push_back(1'b1);
        check("tie_rdata1", rdata1, model_mem[2]);
      end
    end
    clear_drive();
    repeat (3) @(negedge clk);
    check("tie_ack_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("tie_order_%0d", i), (i < order.size()) ? order[i] : 1'bx, exp_ord[i]);
  endtask

  task automatic reset_mid_write();
    int acks = 0;
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'd7; d_wd[0] = 32'hFFFF0000;
    @(posedge clk);
    #2;
    check("rstmid_we_before", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_we_after", mem_we, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    clear_drive();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_rd[0] = '0; hold_rd[1] = '0; m_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    check("rstmid_no_ack", acks, 0);
    check("rstmid_mem7", mem[7], model_mem[7]);
  endtask

  task automatic held_req_test();
    int ack_cyc[$];
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'd2;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ack1) begin
        ack_cyc.push_back(c);
        check("held_rdata1", rdata1, model_mem[2]);
      end
      if (c == 9) d_req[1] = 1'b0;
    end
    hold_rd[1] = model_mem[2];
    check("held_ack_count", ack_cyc.size(), 3);
    for (int i = 1; i < ack_cyc.size(); i++)
      check($sformatf("held_spacing_%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
  endtask

  task automatic new_fields(input int p);
    int r = $urandom_range(15, 0);
    if (r == 0)      d_addr[p] = 32'd256 + $urandom_range(3, 0);
    else if (r == 1) d_addr[p] = $urandom;
    else if (r < 9)  d_addr[p] = $urandom_range(15, 0);
    else             d_addr[p] = $urandom_range(255, 248);
    d_we[p] = $urandom_range(1, 0);
    d_wd[p] = $urandom;
    if (!d_we[p] && d_addr[p] < 32'd256 && !known[d_addr[p][7:0]]) d_we[p] = 1'b1;
  endtask

  // Slot model: the arbiter looks at requests on an edge when free; a grant at edge g owns the
  // memory port for edge g..g+1, acks at g+1 and frees the next look for edge g+3.
  task automatic random_phase(input int ncyc);
    int          k = 0;
    int          next_look = 0;
    bit          pend = 0;
    int          p_g = 0;
    bit          p_port = 0;
    bit          p_we = 0;
    logic [31:0] p_addr = '0;
    bit          e_ack[2];
    bit          e_err;
    int          since[2];
    do_reset();
    since[0] = 0; since[1] = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      k++;
      e_ack[0] = 0; e_ack[1] = 0; e_err = 0;
      if (pend && k == p_g + 1) begin
        e_ack[p_port] = 1;
        e_err = !(p_addr < 32'd256);
        hold_rd[p_port] = (p_we || e_err) ? '0 : model_mem[p_addr[7:0]];
      end
      if (pend && k == p_g + 1 && p_we && p_addr < 32'd256) begin
        model_mem[p_addr[7:0]] = d_wd[p_port];
        known[p_addr[7:0]] = 1'b1;
      end
      if (k >= next_look && (d_req[0] || d_req[1])) begin
`ifdef DMEM_ARB_RR_EN
        p_port = (d_req[0] && d_req[1]) ? !m_last : d_req[1];
`else
        p_port = !d_req[0];
`endif
        m_last = p_port;
        pend = 1; p_g = k; next_look = k + 3;
        p_we = d_we[p_port]; p_addr = d_addr[p_port];
      end
      @(negedge clk);
      check("rnd_ack0", ack0, e_ack[0]);
      check("rnd_ack1", ack1, e_ack[1]);
      check("rnd_err0", err0, e_ack[0] && e_err);
      check("rnd_err1", err1, e_ack[1] && e_err);
      check("rnd_rdata0", rdata0, hold_rd[0]);
      check("rnd_rdata1", rdata1, hold_rd[1]);
      check("rnd_mem_we", mem_we, pend && k == p_g && p_we && p_addr < 32'd256);
      check("rnd_busy", busy, pend && (k == p_g || k == p_g + 1));
      check("rnd_grant", grant_id, p_port);
      if (pend && k == p_g) check("rnd_mem_a", mem_a, p_addr);
`ifdef DMEM_ARB_RR_EN
      // Fresh requests wait at most 4 edges; a request held across its own ack at most 5.
      for (int p = 0; p < 2; p++)
        if (e_ack[p]) check($sformatf("rnd_latency%0d", p), (k - since[p] <= 5), 1'b1);
`endif
      for (int p = 0; p < 2; p++) begin
        if (d_req[p]) begin
          if (e_ack[p]) begin
            if ($urandom_range(1, 0) == 1) begin
              new_fields(p);
              since[p] = k + 1;
            end else begin
              d_req[p] = 1'b0;
            end
          end
        end else if ($urandom_range(2, 0) == 0) begin
          d_req[p] = 1'b1;
          new_fields(p);
          since[p] = k + 1;
        end
      end
    end
    clear_drive();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      known[i] = 1'b0;
      model_mem[i] = '0;
    end
    vecs[0]  = '{1'b0, 1'b1, 32'd5,          32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'd10,         32'h12345678, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'd10,         32'h0,        32'h12345678, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'd0,          32'h11111111, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'd256,        32'h0BADBAD0, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'd0,          32'h0,        32'h11111111, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'd256,        32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'd1,          32'hA1A1A1A1, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'd2,          32'hB2B2B2B2, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'd2,          32'h0,        32'hB2B2B2B2, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'd7,          32'h77770007, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'd7,          32'h0,        32'h77770007, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 1'b1, 32'd255,        32'hCAFE00FF, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'd255,        32'h0,        32'hCAFE00FF, 1'b0};

    clear_drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", ack0, 1'b0);
    check("rst_ack1", ack1, 1'b0);
    check("rst_err0", err0, 1'b0);
    check("rst_err1", err1, 1'b0);
    check("rst_rdata0", rdata0, '0);
    check("rst_rdata1", rdata1, '0);
    check("rst_mem_a", mem_a, '0);
    check("rst_mem_wd", mem_wd, '0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 1'b0);
    rst_n = 1'b1;
    hold_rd[0] = '0; hold_rd[1] = '0; m_last = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 16; i++) run_one(vecs[i], $sformatf("vec%0d", i));
    check("oor_word0_intact", mem[0], 32'h11111111);

    tie_test();
    reset_mid_write();
    run_one(vecs[12], "rstmid_readback");
    held_req_test();
    random_phase(400);

    for (int i = 0; i < 256; i++)
      if (known[i]) check($sformatf("final_mem_%0d", i), mem[i], model_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-cycle data memory, which has a combinational read and a posedge write. It lets two requesters share the memory's single address/write-data/write-enable port: port 0 is the CPU load/store path and port 1 is the test/debug loader. The block serialises accesses through a three-state FSM, captures read data, and returns a one-cycle acknowledge with a range-error flag.

## Interface
Parameters:
- `DW`, default 32: data width.
- `AW`, default 32: address width (word address).
- `DEPTH`, default 256: number of memory words; valid addresses are 0..DEPTH-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: access request; must be held with stable `we`/`addr`/`wdata` until the matching `ack`.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in AW: word address.
- `wdata0` / `wdata1` in DW: write data.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out DW: read result, valid while `ack` is high and held until that port's next ack.
- `err0` / `err1` out 1: out-of-range flag, qualified by `ack`.
- `mem_a` out AW: memory address.
- `mem_wd` out DW: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_rd` in DW: memory read data (combinational from `mem_a`).
- `busy` out 1: high in ACCESS or RESP.
- `grant_id` out 1: port currently or last served.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If no `req` is high, stay in IDLE.
  - Otherwise pick a winner and go to ACCESS.
  - Register `mem_a`, `mem_wd` and `grant_id` from the winner.
  - Set `mem_we` = winner `we` AND `addr < DEPTH`.
- **ACCESS**
  - Memory sees stable outputs for the whole cycle; a write commits at the closing edge.
  - At that edge:
    - Capture `rdata` of the winner from `mem_rd`; capture 0 if the access is a write or out of range.
    - Set the winner's `ack`.
    - Set `err` = (`addr >= DEPTH`).
    - Clear `mem_we`.
    - Go to RESP.
- **RESP**
  - `ack` is high for this cycle only.
  - The closing edge clears `ack` and `err` and returns to IDLE.
- **Arbitration**
  - Round-robin when both ports request: the port not named by `last_grant` wins.
  - `last_grant` updates on every grant and resets to 1, so port 0 wins the first tie.
- **Out-of-range access** never drives `mem_we`; `mem_a` still takes the raw address.
- **Non-winning `rdata`** holds its previous value.

## Timing
- **Reset values:** all outputs 0 (`ack*`, `err*`, `rdata*`, `mem_a`, `mem_wd`, `mem_we`, `busy`, `grant_id`); state = IDLE; `last_grant` = 1.
- **Latency:** a request sampled at edge E0 in IDLE gives `mem_*` valid E0→E1, write commit at E1, `ack` high E1→E2, and IDLE again from E2.
- **Throughput:** the earliest next sample is E3, so one access per 3 cycles. A continuously held `req` is taken as a new transaction at E3.
- **Release rule:** a requester must drop `req` in the cycle after seeing `ack` if it has no further access.
- **Request changes mid-transaction:** `req` changes during ACCESS or RESP are ignored; requests are sampled only in IDLE.
- **Reset mid-operation:** async assertion clears `mem_we` immediately, so no write occurs at the following edge. In-flight transactions are dropped with no `ack`.
- **Simultaneous requests:** the loser is served in the next IDLE slot, so its worst-case wait is 3 extra cycles.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration as described.
- Not defined: fixed priority, port 0 always wins ties; `last_grant` is removed and `grant_id` still reports the served port.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ACCESS`, `ST_RESP`);
  - port-id constants `PORT_CPU` = 0 and `PORT_DBG` = 1.
- Sub-module `dmem_arb_pick`: combinational winner select from `req0`, `req1` and `last_grant`. The macro is honoured inside it.
- Top level holds the FSM, output registers and capture logic.

## Test plan
- **Reset:** hold `rst_n` = 0 → all outputs 0; on release, idle with `busy` = 0.
- **Port 0 write then read:** write addr 5, data 0xDEADBEEF, then read addr 5 → `ack0` at E1→E2 each time, `rdata0` = 0xDEADBEEF, `err0` = 0, `mem_we` high exactly one cycle.
- **Tie:** `req0` = `req1` = 1 continuously, reads at addr 1 and addr 2 → grants alternate 0,1,0,1 with RR; without `DMEM_ARB_RR_EN`, port 0 is always granted.
- **Out-of-range write:** write to addr 256 with `DEPTH` = 256 → `mem_we` never high, `ack0` = 1 with `err0` = 1, memory unchanged.
- **Reset during ACCESS of a write:** `rst_n` low mid-cycle → `mem_we` drops immediately, target word unchanged, no `ack`.
- **Back-to-back held request:** port 1 holds `req1` for 9 cycles → exactly 3 `ack1` pulses spaced 3 cycles apart.
